// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Write-side front end of the integer register file. Merges ALU and load
//   results onto the single register-file write port. A load always wins and
//   is never stalled. A colliding ALU result is parked in a one-entry hold
//   buffer and written on the first load-free cycle. The in-flight write is
//   forwarded combinationally to the two decode read ports.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   alu_valid/ready/dest/data    ALU result handshake (ready = hold empty)
//   load_valid/ready/dest/data   load result (ready tied high)
//   write_enable/dest/data       registered register-file write port
//   read_source1/2               decode read indices
//   bypass_hit1/2, bypass_data1/2  forwarding of the in-flight write
//   conflict_count               saturating count of deferred-ALU cycles
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_destination,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [REG_ADDR_WIDTH-1:0] load_destination,
  input  logic [DATA_WIDTH-1:0]     load_data,
  output logic                      write_enable,
  output logic [REG_ADDR_WIDTH-1:0] write_destination,
  output logic [DATA_WIDTH-1:0]     write_data,
  input  logic [REG_ADDR_WIDTH-1:0] read_source1,
  input  logic [REG_ADDR_WIDTH-1:0] read_source2,
  output logic                      bypass_hit1,
  output logic                      bypass_hit2,
  output logic [DATA_WIDTH-1:0]     bypass_data1,
  output logic [DATA_WIDTH-1:0]     bypass_data2,
  output logic [COUNT_WIDTH-1:0]    conflict_count
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]     data;
  } wb_t;

  logic hold_valid;
  wb_t  hold;
  wb_t  alu_res, load_res, sel;
  logic sel_valid, hold_fill, hold_drain, alu_fire, conflict;

  assign alu_res  = '{dest: alu_destination,  data: alu_data};
  assign load_res = '{dest: load_destination, data: load_data};

  // Ready depends on registered state only, so no valid->ready loop exists.
  assign alu_ready  = !hold_valid;
  assign load_ready = 1'b1;
  assign alu_fire   = alu_valid && alu_ready;
  assign conflict   = load_valid && (hold_valid || alu_fire);

  // Priority load > held ALU > direct ALU. The load is always older than any
  // concurrent or held ALU result, so this order is program order.
  always_comb begin
    sel_valid  = 1'b0;
    sel        = load_res;
    hold_fill  = 1'b0;
    hold_drain = 1'b0;
    if (load_valid) begin
      sel_valid = 1'b1;
      hold_fill = alu_fire;
    end else if (hold_valid) begin
      sel_valid  = 1'b1;
      sel        = hold;
      hold_drain = 1'b1;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel       = alu_res;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold       <= '0;
    end else if (hold_fill) begin
      hold_valid <= 1'b1;
      hold       <= alu_res;
    end else if (hold_drain) begin
      hold_valid <= 1'b0;
    end
  end

  // x0 results are consumed but never strobed into the register file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_enable      <= 1'b0;
      write_destination <= '0;
      write_data        <= '0;
    end else begin
      write_enable <= sel_valid && (sel.dest != '0);
      if (sel_valid) begin
        write_destination <= sel.dest;
        write_data        <= sel.data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      conflict_count <= '0;
    else if (conflict && (conflict_count != '1))
      conflict_count <= conflict_count + 1'b1;
  end

  // Only the registered write is forwarded; a held entry is covered by the
  // decode hazard logic, not by this bypass.
  assign bypass_hit1  = write_enable && (read_source1 != '0) && (write_destination == read_source1);
  assign bypass_hit2  = write_enable && (read_source2 != '0) && (write_destination == read_source2);
  assign bypass_data1 = bypass_hit1 ? write_data : '0;
  assign bypass_data2 = bypass_hit2 ? write_data : '0;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  localparam int CW = 4;  // narrow counter so saturation is reachable

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, load_valid = 1'b0;
  logic [4:0]  alu_destination = '0, load_destination = '0;
  logic [31:0] alu_data = '0, load_data = '0;
  logic [4:0]  read_source1 = '0, read_source2 = '0;
  logic        alu_ready, load_ready, write_enable, bypass_hit1, bypass_hit2;
  logic [4:0]  write_destination;
  logic [31:0] write_data, bypass_data1, bypass_data2;
  logic [CW-1:0] conflict_count;

  writeback_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_destination(alu_destination), .alu_data(alu_data),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_destination(load_destination), .load_data(load_data),
    .write_enable(write_enable), .write_destination(write_destination),
    .write_data(write_data),
    .read_source1(read_source1), .read_source2(read_source2),
    .bypass_hit1(bypass_hit1), .bypass_hit2(bypass_hit2),
    .bypass_data1(bypass_data1), .bypass_data2(bypass_data2),
    .conflict_count(conflict_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] d; logic [31:0] v; } wr_t;
  wr_t exp_q[$];   // writes the register file must see, in order
  wr_t pend_q[$];  // ALU results accepted but not yet written (model)
  int  m_count = 0;
  int  checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic emit(input logic [4:0] d, input logic [31:0] v);
    wr_t w;
    w.d = d; w.v = v;
    if (d != 0) exp_q.push_back(w);
  endtask

  // One clock of stimulus. The model applies the arbitration rules to the
  // inputs driven here; the resulting write appears after the next edge.
  task automatic cycle(input bit av, input logic [4:0] ad, input logic [31:0] adat,
                       input bit lv, input logic [4:0] ld, input logic [31:0] ldat,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit acc, had_hold;
    wr_t w;
    @(posedge clock); #1;
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, pend_q.size() == 0});
    chk("load_ready", {31'b0, load_ready}, 32'd1);
    chk("conflict_count", {28'b0, conflict_count}, m_count);
    alu_valid = av; alu_destination = ad; alu_data = adat;
    load_valid = lv; load_destination = ld; load_data = ldat;
    read_source1 = r1; read_source2 = r2;
    had_hold = pend_q.size() != 0;
    acc = av && !had_hold;
    if (lv) begin
      emit(ld, ldat);
      if (acc) begin w.d = ad; w.v = adat; pend_q.push_back(w); end
    end else if (had_hold) begin
      w = pend_q.pop_front();
      emit(w.d, w.v);
    end else if (acc) begin
      emit(ad, adat);
    end
    if (lv && (had_hold || acc) && m_count < (1 << CW) - 1) m_count++;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // Monitor: compares the write port and bypass against the expected queue.
  initial begin
    wr_t w;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (write_enable) begin
          if (exp_q.size() == 0) begin
            chk("spurious_write", {27'b0, write_destination}, 32'd0);
          end else begin
            w = exp_q.pop_front();
            chk("write_destination", {27'b0, write_destination}, {27'b0, w.d});
            chk("write_data", write_data, w.v);
            chk("bypass_hit1", {31'b0, bypass_hit1}, {31'b0, read_source1 != 0 && read_source1 == w.d});
            chk("bypass_data1", bypass_data1, (read_source1 != 0 && read_source1 == w.d) ? w.v : 32'd0);
            chk("bypass_hit2", {31'b0, bypass_hit2}, {31'b0, read_source2 != 0 && read_source2 == w.d});
            chk("bypass_data2", bypass_data2, (read_source2 != 0 && read_source2 == w.d) ? w.v : 32'd0);
          end
        end else begin
          chk("idle_bypass_hit", {30'b0, bypass_hit1, bypass_hit2}, 32'd0);
          chk("idle_bypass_data", bypass_data1 | bypass_data2, 32'd0);
        end
      end
    end
  end

  initial begin
    #12;
    chk("reset_write_enable", {31'b0, write_enable}, 32'd0);
    chk("reset_write_destination", {27'b0, write_destination}, 32'd0);
    chk("reset_write_data", write_data, 32'd0);
    chk("reset_alu_ready", {31'b0, alu_ready}, 32'd1);
    chk("reset_count", {28'b0, conflict_count}, 32'd0);
    @(posedge clock); #3 reset = 1'b0;

    // Uncontended ALU write
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(5, 0);
    // Collision, then three back-to-back loads with the ALU result held
    cycle(1, 4, 32'h22, 1, 3, 32'h11, 0, 0);
    cycle(1, 9, 32'h99, 1, 6, 32'h61, 3, 4);
    cycle(0, 0, 0, 1, 7, 32'h71, 6, 0);
    cycle(0, 0, 0, 1, 8, 32'h81, 7, 0);
    idle(8, 4);
    idle(4, 0);
    // x0 destination: consumed, never written
    cycle(1, 0, 32'h55, 0, 0, 0, 0, 0);
    idle(0, 0);
    // Bypass of an in-flight write
    cycle(1, 7, 32'hCAFE, 0, 0, 0, 0, 0);
    idle(7, 8);
    idle(0, 0);

    // Reset while an ALU result is held
    cycle(1, 12, 32'hBAD, 1, 13, 32'h1313, 0, 0);
    cycle(0, 0, 0, 1, 14, 32'h1414, 0, 0);
    @(posedge clock); #2;
    reset = 1'b1;
    alu_valid = 0; load_valid = 0;
    #1;
    chk("async_reset_write_enable", {31'b0, write_enable}, 32'd0);
    chk("async_reset_alu_ready", {31'b0, alu_ready}, 32'd1);
    chk("async_reset_count", {28'b0, conflict_count}, 32'd0);
    exp_q.delete(); pend_q.delete(); m_count = 0;
    @(posedge clock); @(posedge clock); #3 reset = 1'b0;
    idle(12, 0);
    idle(12, 14);

    // Randomized traffic; also drives the counter into saturation
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) idle(0, 0);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("saturated_count", {28'b0, conflict_count}, (1 << CW) - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
